ma_filter_param: RTL

Parametrised moving-average filter; next generation of the fixed 4-tap MA_Filter on the sensor/noisy-signal path.
- Window length is 2^LOG2_TAPS and sample width is DATA_W.
- Adds a valid handshake, a running-sum datapath, round-to-nearest output, a history clear and a primed flag.
- Sits between the sample source (ADC/ROM playback) and downstream analysis. One sample in, one averaged sample out.

---
 rtl/ma_pkg.sv | 17 +
 rtl/ma_delay_line.sv | 37 +++
 rtl/ma_filter_param.sv | 84 ++++++++
 3 files changed

// File: rtl/ma_pkg.sv
// Shared sizing helpers for the moving-average filter family.
// Window geometry is derived from LOG2_TAPS so every block agrees on widths.
package ma_pkg;

    function automatic int sum_width(input int data_w, input int log2_taps);
        return data_w + log2_taps;
    endfunction

    function automatic int taps(input int log2_taps);
        return 1 << log2_taps;
    endfunction

    function automatic int round_k(input int log2_taps);
        return 1 << (log2_taps - 1);
    endfunction

endpackage

// File: rtl/ma_delay_line.sv
// Circular sample buffer for the moving-average window.
// The slot under the write pointer is always the oldest sample and is presented combinationally.
module ma_delay_line
    import ma_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LOG2_TAPS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] oldest
);

    localparam int TAPS = taps(LOG2_TAPS);

    logic [DATA_W-1:0]    mem_p1 [TAPS];
    logic [LOG2_TAPS-1:0] ptr_p1;

    assign oldest = mem_p1[ptr_p1];

    // Stage p1: history slots zero on flush so warm-up treats empty taps as 0
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_p1[i] <= '0;
            end
            ptr_p1 <= '0;
        end else if (wr_en) begin
            mem_p1[ptr_p1] <= wr_data;
            ptr_p1         <= ptr_p1 + 1'b1;
        end
    end

endmodule

// File: rtl/ma_filter_param.sv
// Parametrised moving-average filter: running sum over 2^LOG2_TAPS samples,
// round-half-up division, one-cycle latency, history clear and primed flag.
module ma_filter_param
    import ma_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LOG2_TAPS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] noisy_data,
    input  logic              clear,
    output logic              out_valid,
    output logic [DATA_W-1:0] filtered_data,
    output logic              primed
);

    localparam int SUM_W = sum_width(DATA_W, LOG2_TAPS);
    localparam int TAPS  = taps(LOG2_TAPS);
    localparam int CNT_W = LOG2_TAPS + 1;
    localparam logic [SUM_W-1:0] RND  = SUM_W'(round_k(LOG2_TAPS));
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TAPS);

    // Adding half a step before the shift gives round-half-up; the sum
    // tops out at TAPS*(2^DATA_W-1), so adding RND cannot wrap.
    function automatic logic [DATA_W-1:0] round_avg(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] t;
        t = s + RND;
        return t[SUM_W-1:LOG2_TAPS];
    endfunction

    logic              accept_p0;
    logic [DATA_W-1:0] oldest_p0;
    logic [SUM_W-1:0]  sum_next_p0;

    logic [SUM_W-1:0]  sum_p1;
    logic [CNT_W-1:0]  fill_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] avg_p1;

    assign accept_p0   = in_valid & ~clear;
    assign sum_next_p0 = sum_p1 + SUM_W'(noisy_data) - SUM_W'(oldest_p0);

    ma_delay_line #(
        .DATA_W    (DATA_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .wr_en   (accept_p0),
        .wr_data (noisy_data),
        .oldest  (oldest_p0)
    );

    // Stage p1: running sum, rounded output, fill count and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1  <= '0;
            fill_p1 <= '0;
            vld_p1  <= 1'b0;
            avg_p1  <= '0;
        end else if (clear) begin
            sum_p1  <= '0;
            fill_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1 <= sum_next_p0;
                avg_p1 <= round_avg(sum_next_p0);
                if (fill_p1 != FULL) begin
                    fill_p1 <= fill_p1 + 1'b1;
                end
            end
        end
    end

    assign out_valid     = vld_p1;
    assign filtered_data = avg_p1;
    assign primed        = (fill_p1 == FULL);

endmodule
